// File: rtl/program_sequencer.sv
// Fetch/decode/issue sequencer: owns the PC, registers the fetched instruction,
// issues one decoded operation per instruction and resolves jumps internally.
// Optional build macro STEP_LIMIT_EN adds an executed-instruction limit and a timeout flag.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start after reset
// FETCH   | IR <= instruction at PC
// DECODE  | register branch-condition read address
// EXECUTE | issue op / resolve jump / detect HALT or illegal opcode
// HALT    | stopped; start restarts at PC 0 with a freshly latched select
module program_sequencer #(
    parameter int PC_WIDTH  = 8,
    parameter int MAX_STEPS = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [7:0]          program_select,
    output logic [PC_WIDTH-1:0] instr_address,
    output logic [7:0]          instr_program_select,
    input  logic [15:0]         instruction,
    output logic [3:0]          rf_ra_addr,
    input  logic [7:0]          rf_ra_data,
    output logic                exec_valid,
    output logic [3:0]          exec_opcode,
    output logic [3:0]          exec_rd,
    output logic [3:0]          exec_rs1,
    output logic [3:0]          exec_rs2,
    output logic [7:0]          exec_imm8,
    output logic                busy,
    output logic                halted,
`ifdef STEP_LIMIT_EN
    output logic                timeout,
`endif
    output logic                illegal
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_HALT
    } state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [15:0]           ir_q, ir_d;
    logic [7:0]            sel_q, sel_d;
    logic [3:0]            ra_q, ra_d;
    logic [15:0]           xir_q, xir_d;
    logic                  xv_q, xv_d;
    logic                  halted_q, halted_d;
    logic                  illegal_q, illegal_d;
    logic [PC_WIDTH-1:0]   pc_inc, off4, off8;
`ifdef STEP_LIMIT_EN
    logic [15:0]           step_q, step_d;
    logic                  timeout_q, timeout_d;
`endif

    assign pc_inc = pc_q + PC_WIDTH'(1);
    assign off4   = PC_WIDTH'($signed(ir_q[3:0]));
    assign off8   = PC_WIDTH'($signed(ir_q[7:0]));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            sel_q     <= '0;
            ra_q      <= '0;
            xir_q     <= '0;
            xv_q      <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
`ifdef STEP_LIMIT_EN
            step_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            sel_q     <= sel_d;
            ra_q      <= ra_d;
            xir_q     <= xir_d;
            xv_q      <= xv_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
`ifdef STEP_LIMIT_EN
            step_q    <= step_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        sel_d     = sel_q;
        ra_d      = ra_q;
        xir_d     = xir_q;
        xv_d      = 1'b0;
        halted_d  = halted_q;
        illegal_d = illegal_q;
`ifdef STEP_LIMIT_EN
        step_d    = step_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    sel_d     = program_select;
                    pc_d      = '0;
                    halted_d  = 1'b0;
                    illegal_d = 1'b0;
                    state_d   = S_FETCH;
`ifdef STEP_LIMIT_EN
                    step_d    = '0;
                    timeout_d = 1'b0;
`endif
                end
            end
            S_FETCH: begin
                ir_d    = instruction;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ra_d    = ir_q[7:4];
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                state_d = S_FETCH;
                case (ir_q[15:12])
                    4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hB: begin
                        xv_d  = 1'b1;
                        xir_d = ir_q;
                        pc_d  = pc_inc;
                    end
                    4'hC:    pc_d = (rf_ra_data != 8'd0) ? pc_inc + off4 : pc_inc;
                    4'hD:    pc_d = pc_inc + off8;
                    4'hF:    pc_d = pc_inc;
                    4'hE: begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        halted_d  = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
`ifdef STEP_LIMIT_EN
                // The limiting instruction still completes; only the next fetch is suppressed.
                step_d = step_q + 16'd1;
                if (step_d == 16'(MAX_STEPS)) begin
                    timeout_d = 1'b1;
                    halted_d  = 1'b1;
                    state_d   = S_HALT;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign instr_address        = pc_q;
    assign instr_program_select = sel_q;
    assign rf_ra_addr           = ra_q;
    assign exec_valid           = xv_q;
    assign exec_opcode          = xir_q[15:12];
    assign exec_rd              = xir_q[11:8];
    assign exec_rs1             = xir_q[7:4];
    assign exec_rs2             = xir_q[3:0];
    assign exec_imm8            = xir_q[7:0];
    assign busy                 = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                                  (state_q == S_EXECUTE);
    assign halted               = halted_q;
    assign illegal              = illegal_q;
`ifdef STEP_LIMIT_EN
    assign timeout              = timeout_q;
`endif

endmodule
